sound_request_scheduler: RTL and testbench
==========================================

# sound_request_scheduler

- Sits between the chess game-control logic and the buzzer sound player.
- Turns one-cycle or level game events into sound codes, priority-encodes simultaneous events, and buffers them in a small FIFO.
- Issues each code to the player as a `sound_code` plus one-cycle `play_sound` strobe, then watches the player's busy flag so that no request ever retriggers a sound that is still playing.

## Interface
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `ACK_TIMEOUT`, default 16: clk cycles to wait for `busy` to rise after a strobe.
- `GAP_CYCLES`, default 1000000: silent clk cycles enforced between sounds (10 ms at 100 MHz).
- `clk` in 1: system clock, 100 MHz.
- `rstn` in 1: reset, asynchronous, active-low.
- `evt` in [7:1]: event lines; bit k requests code k (1 select, 2 deselect, 3 move, 4 capture, 5 illegal, 6 promote, 7 game over).
- `busy` in 1: player's playing flag (its `start` output).
- `sound_code` out 3: code presented to the player.
- `play_sound` out 1: one-cycle issue strobe.
- `pending` out 1: FIFO non-empty or FSM not in IDLE.
- `drop_cnt` out 8: saturating count of discarded requests.

## Operation
- **Event capture**
  - `evt` is registered; a request is the 0→1 edge of a bit.
  - If several bits rise in the same cycle, only the highest code is kept (7 > 6 > … > 1).
- **Enqueue rules**
  - A code equal to the current FIFO tail entry is coalesced: not enqueued, not counted as a drop.
  - FIFO full: the new code is discarded and `drop_cnt` increments. It saturates at 255.
  - Code 7 flushes all queued entries in the same cycle and is written as the sole entry. It is never dropped. Flushed entries are not counted. An in-flight sound is unaffected.
  - Full FIFO with a dequeue in the same cycle: the enqueue is accepted.
- **FSM states**
  - IDLE: FIFO non-empty → pop the head into `sound_code`, go to ISSUE.
  - ISSUE: `play_sound`=1 for exactly this cycle → WAIT_BUSY.
  - WAIT_BUSY:
    - `busy`=1 → WAIT_DONE.
    - `ACK_TIMEOUT` cycles without `busy` → GAP. The request is lost and `drop_cnt` increments.
  - WAIT_DONE: `busy`=0 → GAP.
  - GAP: count `GAP_CYCLES` cycles → IDLE.
- **Output hold:** `sound_code` is held stable from ISSUE until the next pop. It is never changed while the player could sample it.
- **Busy outside the handshake:** `busy` high while in IDLE (player started externally) blocks popping until `busy` is low.
- **Counter widths:** the GAP counter is `$clog2(GAP_CYCLES+1)` bits. The timeout counter is `$clog2(ACK_TIMEOUT+1)` bits.

## Timing
- **Reset values:** `sound_code`=0, `play_sound`=0, `pending`=0, `drop_cnt`=0. FSM in IDLE, FIFO empty, `evt` register cleared.
- **Reset mid-operation:** everything returns to the reset values immediately. A pending strobe is never emitted.
- **Latency:** `evt` bit rises in cycle N with the FIFO empty and the FSM in IDLE:
  - entry written at the end of N+1;
  - pop in N+2;
  - `play_sound`=1 in N+3 with `sound_code` valid.
- **Back-to-back sounds:** minimum strobe-to-strobe spacing = 1 + busy-rise delay + play time + `GAP_CYCLES` + 2 cycles.
- **`pending`:** registered. It falls the cycle after the FSM enters IDLE with the FIFO empty.
- **Level-held `evt`:** produces exactly one request. A bit dropping and re-rising produces another.

## Structure
- **Package `sound_pkg`:**
  - code constants `SND_NONE`=0, `SND_SELECT`=1, `SND_DESELECT`=2, `SND_MOVE`=3, `SND_CAPTURE`=4, `SND_ILLEGAL`=5, `SND_PROMOTE`=6, `SND_GAMEOVER`=7;
  - the FSM state enum `snd_sched_state_t` (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP).
- **Sub-module `sound_code_fifo`:** DEPTH×3-bit circular buffer with push, pop, flush-and-load, a tail-peek port and full/empty flags. The edge detect, priority encoder, coalescing and FSM stay in the top.

## Test plan
- **Single move:** `evt[3]` pulse at cycle 10 → `play_sound` at cycle 13 with `sound_code`=3. Bench player raises `busy` for 500 cycles; next strobe no earlier than 500+`GAP_CYCLES`.
- **Simultaneous events:** `evt[4]` and `evt[3]` rise together → only code 4 is issued; `drop_cnt`=0.
- **Overflow:** with `busy` held high, push codes 1,2,3,4,5,6 on separate edges (DEPTH=4) → codes 1–4 queued, 5 and 6 dropped, `drop_cnt`=2; codes issue later in order 1,2,3,4.
- **Game over:** with three codes queued, `evt[7]` rises → FIFO holds only 7; the in-flight sound completes; the next strobe carries 7.
- **Lost request:** `busy` never rises → FSM passes WAIT_BUSY after 16 cycles; `drop_cnt`=1; the next queued code issues after the gap.
- **Coalescing and reset:** two move edges while the tail is 3 → one entry. Asserting `rstn`=0 during WAIT_DONE → all outputs 0 and `pending`=0 in the same cycle; no strobe after release until a new event.

Source files
------------

// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - sound codes, scheduler state type and event priority helper
package sound_pkg;

  typedef logic [2:0] snd_code_t;

  localparam snd_code_t SND_NONE     = 3'd0;
  localparam snd_code_t SND_SELECT   = 3'd1;
  localparam snd_code_t SND_DESELECT = 3'd2;
  localparam snd_code_t SND_MOVE     = 3'd3;
  localparam snd_code_t SND_CAPTURE  = 3'd4;
  localparam snd_code_t SND_ILLEGAL  = 3'd5;
  localparam snd_code_t SND_PROMOTE  = 3'd6;
  localparam snd_code_t SND_GAMEOVER = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } snd_sched_state_t;

  // Highest set bit wins; bit k maps directly to code k.
  function automatic snd_code_t prio_code(input logic [7:1] rise);
    snd_code_t c;
    c = SND_NONE;
    for (int k = 1; k <= 7; k++) begin
      if (rise[k]) c = snd_code_t'(k);
    end
    return c;
  endfunction

endpackage

// File: rtl/sound_request_scheduler_if.sv
// rtl/sound_request_scheduler_if.sv - game-event and player handshake bundle
interface sound_request_scheduler_if;
  import sound_pkg::*;

  logic [7:1] evt;
  logic       busy;
  snd_code_t  sound_code;
  logic       play_sound;
  logic       pending;
  logic [7:0] drop_cnt;

  modport master (input evt, busy, output sound_code, play_sound, pending, drop_cnt);
  modport slave  (output evt, busy, input sound_code, play_sound, pending, drop_cnt);

endinterface

// File: rtl/sound_code_fifo.sv
// rtl/sound_code_fifo.sv - circular buffer of sound codes with flush-and-load
module sound_code_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_load,
  input  snd_code_t i_data,
  output snd_code_t o_head,
  output snd_code_t o_tail,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  snd_code_t       r_mem [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [AW:0]     r_cnt;
  logic [AW-1:0]   w_tail_idx;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == (AW+1)'(DEPTH));
  assign w_tail_idx = r_wr - AW'(1);
  assign o_head     = r_mem[r_rd];
  assign o_tail     = r_mem[w_tail_idx];
  assign w_do_push  = i_push && (!o_full || i_pop);
  assign w_do_pop   = i_pop && !o_empty;

  // Load beats push/pop: the popped head was already consumed combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= SND_NONE;
    end else if (i_load) begin
      r_mem[0] <= i_data;
      r_rd     <= '0;
      r_wr     <= AW'(1);
      r_cnt    <= (AW+1)'(1);
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sound_request_scheduler.sv
// rtl/sound_request_scheduler.sv - turns game events into paced buzzer play requests
module sound_request_scheduler
  import sound_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 1000000
) (
  input logic                        clk,
  input logic                        rstn,
  sound_request_scheduler_if.master  bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [7:1]       r_evt;
  logic [7:1]       r_evt_q;
  logic [7:1]       w_rise;
  snd_code_t        w_code;
  snd_code_t        w_head;
  snd_code_t        w_tail;
  logic             w_full;
  logic             w_empty;
  logic             w_is_over;
  logic             w_coalesce;
  logic             w_push;
  logic             w_pop;
  logic             w_drop_full;
  logic             w_drop_to;
  logic [8:0]       w_drop_sum;
  snd_sched_state_t r_state;
  logic [TW-1:0]    r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;
  snd_code_t        r_code;
  logic             r_play;
  logic             r_pending;
  logic [7:0]       r_drop;

  assign w_rise      = r_evt & ~r_evt_q;
  assign w_code      = prio_code(w_rise);
  assign w_is_over   = (w_code == SND_GAMEOVER);
  assign w_coalesce  = !w_empty && (w_tail == w_code);
  assign w_push      = (w_code != SND_NONE) && !w_is_over && !w_coalesce;
  assign w_pop       = (r_state == IDLE) && !w_empty && !bus.busy;
  assign w_drop_full = w_push && w_full && !w_pop;
  assign w_drop_to   = (r_state == WAIT_BUSY) && !bus.busy && (r_to_cnt == TO_LAST);
  assign w_drop_sum  = {1'b0, r_drop} + {8'd0, w_drop_full} + {8'd0, w_drop_to};

  sound_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_load  (w_is_over),
    .i_data  (w_code),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_evt     <= '0;
      r_evt_q   <= '0;
      r_state   <= IDLE;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_code    <= SND_NONE;
      r_play    <= 1'b0;
      r_pending <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_evt     <= bus.evt;
      r_evt_q   <= r_evt;
      r_play    <= 1'b0;
      r_pending <= !w_empty || (r_state != IDLE);
      r_drop    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_code  <= w_head;
            r_play  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.busy) begin
            r_state <= WAIT_DONE;
          end else if (r_to_cnt == TO_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.busy) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state <= IDLE;
          else r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sound_code = r_code;
  assign bus.play_sound = r_play;
  assign bus.pending    = r_pending;
  assign bus.drop_cnt   = r_drop;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// tb/tb_sound_request_scheduler.sv - scoreboard bench for the sound request scheduler
module tb_sound_request_scheduler;
  import sound_pkg::*;

  localparam int GAP = 20;
  localparam int TO  = 16;

  typedef struct {
    logic [7:1] evt;
    snd_code_t  code;
    logic [7:0] drops;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:1] evt;
  logic       force_busy;
  logic       player_busy;
  logic       player_en;
  int         play_len;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         strobe_cyc = 0;
  snd_code_t  exp_q[$];
  vec_t       tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sound_request_scheduler_if bus();
  assign bus.evt  = evt;
  assign bus.busy = force_busy | player_busy;

  sound_request_scheduler #(.DEPTH(4), .ACK_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:1] oh(input int k);
    logic [7:1] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  // Strobe monitor: each strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.play_sound === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got code %0d at cycle %0d, expected no strobe", bus.sound_code, cyc);
      end else begin
        check("strobe_code", 32'(bus.sound_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // Player model: raises busy one cycle after a strobe, for play_len cycles.
  initial begin
    player_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.play_sound === 1'b1 && player_en) begin
        @(posedge clk); #1 player_busy = 1'b1;
        repeat (play_len) @(posedge clk);
        #1 player_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [7:1] b);
    evt = b;
    tick();
    evt = '0;
    tick();
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(strobe_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (bus.pending !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.pending), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    int first;
    int diff;
    rstn = 1'b0; evt = '0; force_busy = 1'b0; player_en = 1'b1; play_len = 500;
    tbl[0] = '{oh(4) | oh(3),         SND_CAPTURE,  8'd0};
    tbl[1] = '{oh(1),                 SND_SELECT,   8'd0};
    tbl[2] = '{oh(7) | oh(2),         SND_GAMEOVER, 8'd0};
    tbl[3] = '{oh(6) | oh(5) | oh(1), SND_PROMOTE,  8'd0};
    tbl[4] = '{oh(2),                 SND_DESELECT, 8'd0};
    tbl[5] = '{oh(5) | oh(3),         SND_ILLEGAL,  8'd0};

    repeat (3) tick();
    check("rst_sound_code", 32'(bus.sound_code), 32'd0);
    check("rst_play_sound", 32'(bus.play_sound), 32'd0);
    check("rst_pending",    32'(bus.pending),    32'd0);
    check("rst_drop_cnt",   32'(bus.drop_cnt),   32'd0);
    rstn = 1'b1;

    // Single move at cycle 10, then a queued select that must respect the gap.
    while (cyc != 10) tick();
    exp_q.push_back(SND_MOVE);
    evt = oh(3);
    tick();
    evt = '0;
    wait_strobes(1, 20, "single_strobe");
    check("single_latency", 32'(strobe_cyc), 32'd13);
    first = strobe_cyc;
    exp_q.push_back(SND_SELECT);
    pulse(oh(1));
    wait_strobes(2, 2000, "single_second_strobe");
    check("single_gap_spacing", 32'((strobe_cyc - first) >= 500 + GAP), 32'd1);
    wait_idle(1000, "single_idle");

    play_len = 5;
    for (int i = 0; i < 6; i++) begin
      s0 = strobe_cnt;
      exp_q.push_back(tbl[i].code);
      pulse(tbl[i].evt);
      wait_strobes(s0 + 1, 30, "vec_strobe");
      wait_idle(200, "vec_idle");
      check("vec_drop_cnt", 32'(bus.drop_cnt), 32'(tbl[i].drops));
      check("vec_strobe_count", 32'(strobe_cnt), 32'(s0 + 1));
    end

    // Overflow with busy held: 1..4 queue, 5 and 6 dropped.
    s0 = strobe_cnt;
    force_busy = 1'b1;
    for (int k = 1; k <= 6; k++) pulse(oh(k));
    for (int k = 1; k <= 4; k++) exp_q.push_back(snd_code_t'(k));
    check("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    check("ovf_no_strobe", 32'(strobe_cnt), 32'(s0));
    check("ovf_pending", 32'(bus.pending), 32'd1);
    force_busy = 1'b0;
    wait_strobes(s0 + 4, 400, "ovf_strobes");
    wait_idle(400, "ovf_idle");

    // Game over flushes queued 2,3,4 while code 1 is playing.
    play_len = 200;
    s0 = strobe_cnt;
    exp_q.push_back(SND_SELECT);
    pulse(oh(1));
    wait_strobes(s0 + 1, 20, "go_first_strobe");
    first = strobe_cyc;
    pulse(oh(2));
    pulse(oh(3));
    pulse(oh(4));
    exp_q.push_back(SND_GAMEOVER);
    pulse(oh(7));
    wait_strobes(s0 + 2, 600, "go_second_strobe");
    check("go_after_inflight", 32'((strobe_cyc - first) >= 200 + GAP), 32'd1);
    wait_idle(600, "go_idle");
    check("go_strobe_count", 32'(strobe_cnt), 32'(s0 + 2));
    check("go_drop_cnt", 32'(bus.drop_cnt), 32'd2);

    // Player ignores the first strobe: timeout drop, then the next code issues.
    play_len = 5;
    player_en = 1'b0;
    s0 = strobe_cnt;
    exp_q.push_back(SND_ILLEGAL);
    pulse(oh(5));
    wait_strobes(s0 + 1, 20, "lost_first_strobe");
    first = strobe_cyc;
    exp_q.push_back(SND_PROMOTE);
    pulse(oh(6));
    player_en = 1'b1;
    wait_strobes(s0 + 2, 200, "lost_second_strobe");
    diff = strobe_cyc - first;
    check("lost_spacing", 32'(diff >= TO + GAP && diff <= TO + GAP + 4), 32'd1);
    wait_idle(200, "lost_idle");
    check("lost_drop_cnt", 32'(bus.drop_cnt), 32'd3);

    // Coalescing and level-held events under an external busy.
    s0 = strobe_cnt;
    force_busy = 1'b1;
    exp_q.push_back(SND_MOVE);
    pulse(oh(3));
    pulse(oh(3));
    exp_q.push_back(SND_DESELECT);
    evt = oh(2);
    repeat (10) tick();
    evt = '0;
    tick();
    check("coal_drop_cnt", 32'(bus.drop_cnt), 32'd3);
    force_busy = 1'b0;
    wait_strobes(s0 + 2, 200, "coal_strobes");
    wait_idle(200, "coal_idle");
    check("coal_strobe_count", 32'(strobe_cnt), 32'(s0 + 2));

    // Reset during WAIT_DONE with a code queued behind the playing one.
    play_len = 300;
    s0 = strobe_cnt;
    exp_q.push_back(SND_CAPTURE);
    pulse(oh(4));
    wait_strobes(s0 + 1, 20, "rstm_strobe");
    pulse(oh(1));
    repeat (20) tick();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstm_sound_code", 32'(bus.sound_code), 32'd0);
    check("rstm_play_sound", 32'(bus.play_sound), 32'd0);
    check("rstm_pending",    32'(bus.pending),    32'd0);
    check("rstm_drop_cnt",   32'(bus.drop_cnt),   32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (100) tick();
    check("rstm_no_strobe", 32'(strobe_cnt), 32'(s0 + 1));
    exp_q.push_back(SND_PROMOTE);
    pulse(oh(6));
    wait_strobes(s0 + 2, 800, "rstm_new_strobe");
    wait_idle(1000, "rstm_idle");
    check("rstm_final_drop", 32'(bus.drop_cnt), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
